// File: rtl/pwm_phase_array.sv
// Eight-channel phase-shifted PWM generator sharing one carrier counter.
// Define PWM_PHASE_SHADOW_EN for shadowed phase writes that commit at the carrier wrap.
module pwm_phase_array #(
    parameter int PERIOD = 675,
    parameter int DUTY   = 337
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_ch,
    input  logic [9:0] cfg_phase,
    output logic [7:0] change_pwm,
    output logic       period_start
);

    localparam logic [9:0]  PMAX   = 10'(PERIOD - 1);
    localparam logic [10:0] PER11  = 11'(PERIOD);
    localparam logic [10:0] DUTY11 = 11'(DUTY);

    logic [9:0]  cnt;
    logic [9:0]  ph [8];
    logic [10:0] rel [8];
    logic [9:0]  phase_sat;
    logic [7:0]  pwm_next;
    logic        wrap;
    logic        accept;

    // Writes are never stalled; the handshake only drops while reset is held.
    assign cfg_ready = rst_n;
    assign accept    = cfg_valid & cfg_ready;
    assign wrap      = en && (cnt == PMAX);
    assign phase_sat = (cfg_phase >= PMAX) ? PMAX : cfg_phase;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 10'd1;
        end
    end

`ifdef PWM_PHASE_SHADOW_EN
    logic [9:0] sh [8];
    logic [7:0] pend;
    logic       commit;

    // A disabled carrier has no period boundary to wait for, so writes land at once.
    assign commit = wrap || !en;

    // NOTE: the phase array is eight flop registers, not a RAM, so it is safe to clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                ph[i] <= '0;
                sh[i] <= '0;
            end
            pend <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (commit) begin
                    // A write landing on the wrap edge beats the older shadow value.
                    if (accept && cfg_ch == 3'(i)) begin
                        ph[i] <= phase_sat;
                    end else if (pend[i]) begin
                        ph[i] <= sh[i];
                    end
                    pend[i] <= 1'b0;
                end else if (accept && cfg_ch == 3'(i)) begin
                    sh[i]   <= phase_sat;
                    pend[i] <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                ph[i] <= '0;
            end
        end else if (accept) begin
            ph[cfg_ch] <= phase_sat;
        end
    end
`endif

    // Position of the carrier relative to each channel's delayed start, kept within 11 bits.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if ({1'b0, cnt} >= {1'b0, ph[i]}) begin
                rel[i] = {1'b0, cnt} - {1'b0, ph[i]};
            end else begin
                rel[i] = {1'b0, cnt} + PER11 - {1'b0, ph[i]};
            end
            pwm_next[i] = en && (rel[i] < DUTY11);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change_pwm   <= '0;
            period_start <= 1'b0;
        end else begin
            change_pwm   <= pwm_next;
            period_start <= en && (cnt == 10'd0);
        end
    end

endmodule

// File: tb/tb_pwm_phase_array.sv
// Scoreboard bench for pwm_phase_array: the driver queues expected output snapshots
// keyed by clock count, and a negedge monitor compares them as the DUT reaches them.
module tb_pwm_phase_array;

    localparam int P = 675;
`ifdef PWM_PHASE_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_ch = '0;
    logic [9:0] cfg_phase = '0;
    logic [7:0] change_pwm;
    logic       period_start;

    pwm_phase_array dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_phase    (cfg_phase),
        .change_pwm   (change_pwm),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] mask;
        logic [7:0] pwm;
        logic       ps;
        logic       rdy;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Rising edges since the last reset release; after edge k the outputs reflect cnt = (k-1) mod P.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: compare every queued snapshot whose cycle has arrived.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: snapshot for cycle %0d missed (now %0d)", q[i].name, q[i].at, cyc);
                q.delete(i);
            end else if (q[i].at == cyc) begin
                checks++;
                if ((change_pwm & q[i].mask) !== q[i].pwm || period_start !== q[i].ps ||
                    cfg_ready !== q[i].rdy) begin
                    failures++;
                    $display("FAIL %s: pwm=%h ps=%b rdy=%b, wanted pwm=%h (mask %h) ps=%b rdy=%b",
                             q[i].name, change_pwm & q[i].mask, period_start, cfg_ready,
                             q[i].pwm, q[i].mask, q[i].ps, q[i].rdy);
                end
                q.delete(i);
            end
        end
    end

    task automatic push_abs(input int at, input logic [7:0] mask, input logic [7:0] pwm,
                            input logic ps, input logic rdy, input string name);
        exp_t e;
        e.at = at; e.mask = mask; e.pwm = pwm; e.ps = ps; e.rdy = rdy; e.name = name;
        q.push_back(e);
    endtask

    // Expect the outputs that reflect counter value c in carrier period per.
    task automatic push(input int per, input int c, input logic [7:0] mask,
                        input logic [7:0] pwm, input string name);
        push_abs(per * P + c + 1, mask, pwm, (c == 0), 1'b1, name);
    endtask

    task automatic wait_cyc(input int t);
        int n = 0;
        while (cyc != t && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != t) begin
            checks++;
            failures++;
            $display("FAIL wait_cyc: reached %0d, required %0d", cyc, t);
        end
    endtask

    // Offer one write for one clock; it is accepted on the next rising edge.
    task automatic do_write(input logic [2:0] ch, input logic [9:0] phase);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_phase = phase;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        push_abs(0, 8'hFF, 8'h00, 1'b0, 1'b0, "reset_state");
        repeat (3) @(negedge clk);
        en    = 1'b1;
        rst_n = 1'b1;

        // All phases zero: every channel high for cnt 0..336.
        push(0, 0,   8'hFF, 8'hFF, "p0_cnt0");
        push(0, 1,   8'hFF, 8'hFF, "p0_cnt1");
        push(0, 336, 8'hFF, 8'hFF, "p0_cnt336");
        push(0, 337, 8'hFF, 8'h00, "p0_cnt337");
        push(0, 674, 8'hFF, 8'h00, "p0_cnt674");
        push(1, 0,   8'hFF, 8'hFF, "p1_cnt0");

        wait_cyc(P + 5);
        do_write(3'd3, 10'd100);
        do_write(3'd5, 10'd600);
        do_write(3'd2, 10'd1000);
        cfg_valid = 1'b0;
        // ph = {0,0,674,100,0,600,0,0}
        push(2, 0,   8'hFF, 8'hF7, "p2_vector_cnt0");
        push(2, 99,  8'h08, 8'h00, "ch3_before_rise");
        push(2, 100, 8'h08, 8'h08, "ch3_rise");
        push(2, 436, 8'h08, 8'h08, "ch3_before_fall");
        push(2, 437, 8'h08, 8'h00, "ch3_fall");
        push(2, 261, 8'h20, 8'h20, "ch5_wrap_last_high");
        push(2, 262, 8'h20, 8'h00, "ch5_wrap_fall");
        push(2, 599, 8'h20, 8'h00, "ch5_before_rise");
        push(2, 600, 8'h20, 8'h20, "ch5_rise");
        push(2, 335, 8'h04, 8'h04, "ch2_sat_high");
        push(2, 336, 8'h04, 8'h00, "ch2_sat_fall");
        push(2, 673, 8'h04, 8'h00, "ch2_sat_low");
        push(2, 674, 8'h04, 8'h04, "ch2_sat_rise");
        push(2, 336, 8'h01, 8'h01, "ch0_high");
        push(2, 337, 8'h01, 8'h00, "ch0_fall");

        // Phase write at cnt=10: shadowed builds wait for the wrap.
        wait_cyc(3 * P + 10);
        do_write(3'd1, 10'd50);
        push(3, 20,  8'h02, SHADOW ? 8'h02 : 8'h00, "ch1_midperiod_cnt20");
        push(3, 360, 8'h02, SHADOW ? 8'h00 : 8'h02, "ch1_midperiod_cnt360");
        push(4, 20,  8'h02, 8'h00, "ch1_next_cnt20");
        push(4, 49,  8'h02, 8'h00, "ch1_next_cnt49");
        push(4, 50,  8'h02, 8'h02, "ch1_next_rise");
        push(4, 386, 8'h02, 8'h02, "ch1_next_cnt386");
        push(4, 387, 8'h02, 8'h00, "ch1_next_fall");

        // Back-to-back writes to one channel: the later value wins.
        wait_cyc(4 * P + 100);
        do_write(3'd6, 10'd200);
        do_write(3'd6, 10'd400);
        push(5, 61,  8'h40, 8'h40, "ch6_last_wins_high");
        push(5, 62,  8'h40, 8'h00, "ch6_last_wins_fall");
        push(5, 399, 8'h40, 8'h00, "ch6_last_wins_low");
        push(5, 400, 8'h40, 8'h40, "ch6_last_wins_rise");

        // Write accepted on the wrap edge commits for the very next period.
        wait_cyc(5 * P + 674);
        do_write(3'd7, 10'd300);
        push(6, 0,   8'h80, 8'h00, "ch7_wrap_write_cnt0");
        push(6, 299, 8'h80, 8'h00, "ch7_wrap_write_cnt299");
        push(6, 300, 8'h80, 8'h80, "ch7_wrap_write_rise");
        push(6, 636, 8'h80, 8'h80, "ch7_wrap_write_cnt636");
        push(6, 637, 8'h80, 8'h00, "ch7_wrap_write_fall");

        // Reset at cnt=300 with a write still pending.
        wait_cyc(7 * P + 299);
        cfg_valid = 1'b1;
        cfg_ch    = 3'd3;
        cfg_phase = 10'd500;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        push_abs(0, 8'hFF, 8'h00, 1'b0, 1'b0, "reset_midperiod");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(0, 0,   8'hFF, 8'hFF, "post_rst_cnt0");
        push(0, 336, 8'h08, 8'h08, "post_rst_ch3_high");
        push(0, 337, 8'hFF, 8'h00, "post_rst_cnt337");
        push(1, 0,   8'hFF, 8'hFF, "post_rst_p1_cnt0");
        push(1, 336, 8'hFF, 8'hFF, "post_rst_p1_cnt336");
        push(1, 337, 8'hFF, 8'h00, "post_rst_p1_cnt337");
        push(1, 500, 8'h08, 8'h00, "post_rst_write_lost");

        // Disabling forces outputs low and the counter back to zero.
        wait_cyc(2 * P + 10);
        en = 1'b0;
        push_abs(2 * P + 11, 8'hFF, 8'h00, 1'b0, 1'b1, "en_off");
        wait_cyc(2 * P + 20);
        en = 1'b1;
        push_abs(2 * P + 21, 8'hFF, 8'hFF, 1'b1, 1'b1, "en_restart_cnt0");
        push_abs(2 * P + 22, 8'hFF, 8'hFF, 1'b0, 1'b1, "en_restart_cnt1");

        for (int n = 0; n < 2000 && q.size() > 0; n++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d snapshots unchecked, required 0", q.size());
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
